// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and LSU wait stalls,
// plus forwarding flags, a sticky LSU-timeout flag and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
  parameter logic [1:0] WB_SEL_LOAD  = 2'd1,
  parameter int         MAX_MEM_WAIT = 16,
  parameter int         CNT_W        = 16,
  localparam int        WAIT_W       = $clog2(MAX_MEM_WAIT + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       ID_i_inst,
  input  logic              ID_i_rs1_used,
  input  logic              ID_i_rs2_used,
  input  logic [31:0]       EX_i_inst,
  input  logic              EX_i_reg_wren,
  input  logic [1:0]        EX_i_wb_sel,
  input  logic              EX_i_pc_sel,
  input  logic [31:0]       MEM_i_inst,
  input  logic              MEM_i_reg_wren,
  input  logic              i_lsu_busy,
  output logic              o_pc_stall,
  output logic              o_ifid_stall,
  output logic              o_ifid_flush,
  output logic              o_idex_stall,
  output logic              o_idex_flush,
  output logic              o_exmem_stall,
  output logic              ID_o_rs1_hazard_on,
  output logic              ID_o_rs2_hazard_on,
  output logic              o_mem_timeout,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic              o_dbg_state,
  output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX_M1 = WAIT_W'(MAX_MEM_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic [4:0] mem_rd;

  logic rs1_ex;
  logic rs2_ex;
  logic rs1_mem;
  logic rs2_mem;
  logic load_use;

  assign id_rs1 = ID_i_inst[19:15];
  assign id_rs2 = ID_i_inst[24:20];
  assign ex_rd  = EX_i_inst[11:7];
  assign mem_rd = MEM_i_inst[11:7];

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  assign rs1_ex  = ID_i_rs1_used & (id_rs1 != 5'd0) & EX_i_reg_wren  & (ex_rd  == id_rs1);
  assign rs2_ex  = ID_i_rs2_used & (id_rs2 != 5'd0) & EX_i_reg_wren  & (ex_rd  == id_rs2);
  assign rs1_mem = ID_i_rs1_used & (id_rs1 != 5'd0) & MEM_i_reg_wren & (mem_rd == id_rs1);
  assign rs2_mem = ID_i_rs2_used & (id_rs2 != 5'd0) & MEM_i_reg_wren & (mem_rd == id_rs2);

  assign load_use = (rs1_ex | rs2_ex) & (EX_i_wb_sel == WB_SEL_LOAD);

  // LSU wait outranks a redirect (the redirect is replayed once the LSU frees up);
  // a redirect outranks load-use because the dependent ID instruction is squashed anyway.
  always_comb begin
    o_pc_stall         = 1'b0;
    o_ifid_stall       = 1'b0;
    o_ifid_flush       = 1'b0;
    o_idex_stall       = 1'b0;
    o_idex_flush       = 1'b0;
    o_exmem_stall      = 1'b0;
    ID_o_rs1_hazard_on = 1'b0;
    ID_o_rs2_hazard_on = 1'b0;
    if (i_reset_n) begin
      ID_o_rs1_hazard_on = rs1_ex | rs1_mem;
      ID_o_rs2_hazard_on = rs2_ex | rs2_mem;
      if (i_lsu_busy) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_stall  = 1'b1;
        o_exmem_stall = 1'b1;
      end else if (EX_i_pc_sel) begin
        o_ifid_flush  = 1'b1;
        o_idex_flush  = 1'b1;
      end else if (load_use) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_flush  = 1'b1;
      end
    end
  end

  // LSU wait tracker: counts consecutive busy cycles and latches a sticky timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (i_lsu_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        MEM_WAIT: begin
          if (i_lsu_busy) begin
            if (wait_cnt != WAIT_MAX) begin
              wait_cnt <= wait_cnt + WAIT_ONE;
              if (wait_cnt == WAIT_MAX_M1) begin
                o_mem_timeout <= 1'b1;
              end
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cycles <= '0;
    end else if (o_pc_stall && (o_stall_cycles != {CNT_W{1'b1}})) begin
      o_stall_cycles <= o_stall_cycles + CNT_ONE;
    end
  end

  assign o_dbg_state    = state;
  assign o_dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: load-use, x0/unused operands, redirect priority,
// LSU wait stalls, sticky timeout and asynchronous reset during a wait.
module tb_hazard_ctrl_unit;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:0] ID_i_inst;
  logic        ID_i_rs1_used;
  logic        ID_i_rs2_used;
  logic [31:0] EX_i_inst;
  logic        EX_i_reg_wren;
  logic [1:0]  EX_i_wb_sel;
  logic        EX_i_pc_sel;
  logic [31:0] MEM_i_inst;
  logic        MEM_i_reg_wren;
  logic        i_lsu_busy;
  logic        o_pc_stall;
  logic        o_ifid_stall;
  logic        o_ifid_flush;
  logic        o_idex_stall;
  logic        o_idex_flush;
  logic        o_exmem_stall;
  logic        ID_o_rs1_hazard_on;
  logic        ID_o_rs2_hazard_on;
  logic        o_mem_timeout;
  logic [15:0] o_stall_cycles;
  logic        o_dbg_state;
  logic [4:0]  o_dbg_wait_cnt;

  int n_cmp;
  int n_err;

  hazard_ctrl_unit dut (
    .i_clk              (i_clk),
    .i_reset_n          (i_reset_n),
    .ID_i_inst          (ID_i_inst),
    .ID_i_rs1_used      (ID_i_rs1_used),
    .ID_i_rs2_used      (ID_i_rs2_used),
    .EX_i_inst          (EX_i_inst),
    .EX_i_reg_wren      (EX_i_reg_wren),
    .EX_i_wb_sel        (EX_i_wb_sel),
    .EX_i_pc_sel        (EX_i_pc_sel),
    .MEM_i_inst         (MEM_i_inst),
    .MEM_i_reg_wren     (MEM_i_reg_wren),
    .i_lsu_busy         (i_lsu_busy),
    .o_pc_stall         (o_pc_stall),
    .o_ifid_stall       (o_ifid_stall),
    .o_ifid_flush       (o_ifid_flush),
    .o_idex_stall       (o_idex_stall),
    .o_idex_flush       (o_idex_flush),
    .o_exmem_stall      (o_exmem_stall),
    .ID_o_rs1_hazard_on (ID_o_rs1_hazard_on),
    .ID_o_rs2_hazard_on (ID_o_rs2_hazard_on),
    .o_mem_timeout      (o_mem_timeout),
    .o_stall_cycles     (o_stall_cycles),
    .o_dbg_state        (o_dbg_state),
    .o_dbg_wait_cnt     (o_dbg_wait_cnt)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    mk_inst = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
  function automatic logic [5:0] ctrl_vec();
    ctrl_vec = {o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush, o_exmem_stall};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] exp_ctrl, input logic [1:0] exp_haz);
    check({tag, "_ctrl"}, {26'd0, ctrl_vec()}, {26'd0, exp_ctrl});
    check({tag, "_haz"}, {30'd0, ID_o_rs1_hazard_on, ID_o_rs2_hazard_on}, {30'd0, exp_haz});
  endtask

  task automatic clear_inputs();
    ID_i_inst      = 32'd0;
    ID_i_rs1_used  = 1'b0;
    ID_i_rs2_used  = 1'b0;
    EX_i_inst      = 32'd0;
    EX_i_reg_wren  = 1'b0;
    EX_i_wb_sel    = 2'd0;
    EX_i_pc_sel    = 1'b0;
    MEM_i_inst     = 32'd0;
    MEM_i_reg_wren = 1'b0;
    i_lsu_busy     = 1'b0;
  endtask

  // advance one rising edge; inputs change only at falling edges
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic pulse_reset();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    i_reset_n = 1'b0;
    @(negedge i_clk);

    // reset state, with a load-use pattern present to prove outputs are forced low
    ID_i_inst = mk_inst(5'd6, 5'd5, 5'd7); ID_i_rs1_used = 1'b1;
    EX_i_inst = mk_inst(5'd5, 5'd0, 5'd0); EX_i_reg_wren = 1'b1; EX_i_wb_sel = 2'd1;
    i_lsu_busy = 1'b1;
    #1;
    check_ctrl("reset", 6'b000000, 2'b00);
    check("reset_cnt", {16'd0, o_stall_cycles}, 32'd0);
    check("reset_tmo", {31'd0, o_mem_timeout}, 32'd0);
    check("reset_state", {31'd0, o_dbg_state}, 32'd0);
    clear_inputs();
    i_reset_n = 1'b1;
    tick();

    #1;
    check_ctrl("idle", 6'b000000, 2'b00);

    // test 1: lw x5 in EX, add x6,x5,x7 in ID
    ID_i_inst = mk_inst(5'd6, 5'd5, 5'd7); ID_i_rs1_used = 1'b1; ID_i_rs2_used = 1'b1;
    EX_i_inst = mk_inst(5'd5, 5'd0, 5'd0); EX_i_reg_wren = 1'b1; EX_i_wb_sel = 2'd1;
    #1;
    check_ctrl("lu", 6'b110010, 2'b10);
    tick();
    // lw now in MEM, bubble in EX
    EX_i_inst = 32'd0; EX_i_reg_wren = 1'b0; EX_i_wb_sel = 2'd0;
    MEM_i_inst = mk_inst(5'd5, 5'd0, 5'd0); MEM_i_reg_wren = 1'b1;
    #1;
    check_ctrl("lu_mem_fwd", 6'b000000, 2'b10);
    check("lu_cnt", {16'd0, o_stall_cycles}, 32'd1);
    tick();

    // ALU producer in EX matching rs2: forward, no stall
    clear_inputs();
    ID_i_inst = mk_inst(5'd6, 5'd7, 5'd5); ID_i_rs1_used = 1'b1; ID_i_rs2_used = 1'b1;
    EX_i_inst = mk_inst(5'd5, 5'd0, 5'd0); EX_i_reg_wren = 1'b1; EX_i_wb_sel = 2'd0;
    #1;
    check_ctrl("alu_fwd_rs2", 6'b000000, 2'b01);
    tick();

    // test 2a: load to x0 read as rs1=x0
    clear_inputs();
    ID_i_inst = mk_inst(5'd6, 5'd0, 5'd7); ID_i_rs1_used = 1'b1; ID_i_rs2_used = 1'b1;
    EX_i_inst = mk_inst(5'd0, 5'd0, 5'd0); EX_i_reg_wren = 1'b1; EX_i_wb_sel = 2'd1;
    MEM_i_inst = mk_inst(5'd0, 5'd0, 5'd0); MEM_i_reg_wren = 1'b1;
    #1;
    check_ctrl("x0", 6'b000000, 2'b00);
    tick();

    // test 2b: rs1 matches but is not used
    clear_inputs();
    ID_i_inst = mk_inst(5'd6, 5'd5, 5'd7); ID_i_rs1_used = 1'b0; ID_i_rs2_used = 1'b1;
    EX_i_inst = mk_inst(5'd5, 5'd0, 5'd0); EX_i_reg_wren = 1'b1; EX_i_wb_sel = 2'd1;
    #1;
    check_ctrl("rs1_unused", 6'b000000, 2'b00);
    tick();

    // test 3: redirect together with load-use
    ID_i_rs1_used = 1'b1;
    EX_i_pc_sel = 1'b1;
    #1;
    check_ctrl("redirect_lu", 6'b001010, 2'b10);
    tick();
    clear_inputs();
    #1;
    check("redirect_cnt", {16'd0, o_stall_cycles}, 32'd1);

    // test 4: LSU busy 3 cycles while a redirect waits
    pulse_reset();
    #1;
    check("t4_cnt0", {16'd0, o_stall_cycles}, 32'd0);
    EX_i_pc_sel = 1'b1;
    i_lsu_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check_ctrl($sformatf("busy%0d", i), 6'b110101, 2'b00);
      tick();
    end
    check("t4_state", {31'd0, o_dbg_state}, 32'd1);
    check("t4_wait", {27'd0, o_dbg_wait_cnt}, 32'd3);
    i_lsu_busy = 1'b0;
    #1;
    check_ctrl("busy_drop", 6'b001010, 2'b00);
    check("t4_cnt3", {16'd0, o_stall_cycles}, 32'd3);
    tick();
    clear_inputs();
    #1;
    check("t4_state_run", {31'd0, o_dbg_state}, 32'd0);
    check("t4_wait0", {27'd0, o_dbg_wait_cnt}, 32'd0);
    check("t4_cnt_hold", {16'd0, o_stall_cycles}, 32'd3);

    // test 5: busy for 17 edges; timeout appears after the 16th
    i_lsu_busy = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      #1;
      if (i == 15) begin
        check("t5_wait15", {27'd0, o_dbg_wait_cnt}, 32'd15);
        check("t5_tmo15", {31'd0, o_mem_timeout}, 32'd0);
      end
      if (i == 16) begin
        check("t5_wait16", {27'd0, o_dbg_wait_cnt}, 32'd16);
        check("t5_tmo16", {31'd0, o_mem_timeout}, 32'd1);
      end
      if (i == 17) begin
        check("t5_wait_sat", {27'd0, o_dbg_wait_cnt}, 32'd16);
      end
    end
    i_lsu_busy = 1'b0;
    tick();
    #1;
    check("t5_tmo_sticky", {31'd0, o_mem_timeout}, 32'd1);
    check("t5_state_run", {31'd0, o_dbg_state}, 32'd0);
    check("t5_cnt", {16'd0, o_stall_cycles}, 32'd20);
    tick();
    #1;
    check("t5_tmo_sticky2", {31'd0, o_mem_timeout}, 32'd1);

    // test 6: reset asserted mid-wait
    i_lsu_busy = 1'b1;
    tick();
    tick();
    #1;
    check("t6_state_wait", {31'd0, o_dbg_state}, 32'd1);
    i_reset_n = 1'b0;
    #1;
    check_ctrl("t6_rst", 6'b000000, 2'b00);
    check("t6_rst_cnt", {16'd0, o_stall_cycles}, 32'd0);
    check("t6_rst_tmo", {31'd0, o_mem_timeout}, 32'd0);
    check("t6_rst_state", {31'd0, o_dbg_state}, 32'd0);
    tick();
    i_lsu_busy = 1'b0;
    i_reset_n = 1'b1;
    tick();
    #1;
    check("t6_state", {31'd0, o_dbg_state}, 32'd0);
    check("t6_wait", {27'd0, o_dbg_wait_cnt}, 32'd0);
    check("t6_tmo", {31'd0, o_mem_timeout}, 32'd0);
    check("t6_cnt", {16'd0, o_stall_cycles}, 32'd0);
    check_ctrl("t6_idle", 6'b000000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
